// File: rtl/gate_pipe_pkg.sv
// Shared definitions for gate_pipe: function-select codes and skid buffer state encoding.
package gate_pipe_pkg;

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_XOR  = 3'd2;
    localparam logic [2:0] OP_NAND = 3'd3;
    localparam logic [2:0] OP_NOR  = 3'd4;
    localparam logic [2:0] OP_XNOR = 3'd5;
    localparam logic [2:0] OP_NOT  = 3'd6;
    localparam logic [2:0] OP_BUF  = 3'd7;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } skid_state_e;

endpackage

// File: rtl/gate_reduce.sv
// Combinational bitwise reduction of NIN operands of WIDTH bits under a 3-bit function select.
module gate_reduce
    import gate_pipe_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NIN   = 2
) (
    input  logic [NIN*WIDTH-1:0] in_data,
    input  logic [2:0]           op,
    output logic [WIDTH-1:0]     result
);

    logic [WIDTH-1:0] and_v;
    logic [WIDTH-1:0] or_v;
    logic [WIDTH-1:0] xor_v;
    logic [WIDTH-1:0] opnd0;

    // Fold all operands into AND/OR/XOR vectors, then pick or invert per op.
    always_comb begin
        and_v  = {WIDTH{1'b1}};
        or_v   = {WIDTH{1'b0}};
        xor_v  = {WIDTH{1'b0}};
        opnd0  = in_data[WIDTH-1:0];
        for (int k = 0; k < NIN; k++) begin
            and_v = and_v & in_data[k*WIDTH +: WIDTH];
            or_v  = or_v  | in_data[k*WIDTH +: WIDTH];
            xor_v = xor_v ^ in_data[k*WIDTH +: WIDTH];
        end
        case (op)
            OP_AND:  result = and_v;
            OP_OR:   result = or_v;
            OP_XOR:  result = xor_v;
            OP_NAND: result = ~and_v;
            OP_NOR:  result = ~or_v;
            OP_XNOR: result = ~xor_v;
            OP_NOT:  result = ~opnd0;
            OP_BUF:  result = opnd0;
            default: result = {WIDTH{1'b0}};
        endcase
    end

endmodule

// File: rtl/gate_pipe.sv
// Registered multi-operand logic gate behind a 2-entry skid buffer (main M, skid S)
// with a registered in_ready and a wrapping accepted-transaction counter.
module gate_pipe
    import gate_pipe_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NIN   = 2,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           in_op,
    input  logic [NIN*WIDTH-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [2:0]           out_op,
    output logic [CNT_W-1:0]     acc_count
);

    skid_state_e      state_q, state_d;
    logic [WIDTH-1:0] m_data_q, m_data_d;
    logic [WIDTH-1:0] s_data_q, s_data_d;
    logic [2:0]       m_op_q, m_op_d;
    logic [2:0]       s_op_q, s_op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             in_ready_q, out_valid_q;
    logic [WIDTH-1:0] result_s;
    logic             in_fire_s, out_fire_s;

    gate_reduce #(
        .WIDTH (WIDTH),
        .NIN   (NIN)
    ) u_reduce (
        .in_data (in_data),
        .op      (in_op),
        .result  (result_s)
    );

    assign in_fire_s  = in_valid && in_ready_q;
    assign out_fire_s = out_valid_q && out_ready;

    // Skid buffer next-state and data steering; results enter M when it frees up, else S.
    always_comb begin
        state_d  = state_q;
        m_data_d = m_data_q;
        m_op_d   = m_op_q;
        s_data_d = s_data_q;
        s_op_d   = s_op_q;
        cnt_d    = in_fire_s ? cnt_q + CNT_W'(1) : cnt_q;
        case (state_q)
            EMPTY: begin
                if (in_fire_s) begin
                    m_data_d = result_s;
                    m_op_d   = in_op;
                    state_d  = ONE;
                end else begin
                    state_d  = EMPTY;
                end
            end
            ONE: begin
                if (in_fire_s && !out_fire_s) begin
                    s_data_d = result_s;
                    s_op_d   = in_op;
                    state_d  = FULL;
                end else if (in_fire_s && out_fire_s) begin
                    m_data_d = result_s;
                    m_op_d   = in_op;
                    state_d  = ONE;
                end else if (out_fire_s) begin
                    state_d  = EMPTY;
                end else begin
                    state_d  = ONE;
                end
            end
            FULL: begin
                if (out_fire_s) begin
                    m_data_d = s_data_q;
                    m_op_d   = s_op_q;
                    state_d  = ONE;
                end else begin
                    state_d  = FULL;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
    end

    // State, data and handshake registers; flags are derived from the next state so they stay registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= EMPTY;
            m_data_q    <= {WIDTH{1'b0}};
            m_op_q      <= 3'd0;
            s_data_q    <= {WIDTH{1'b0}};
            s_op_q      <= 3'd0;
            cnt_q       <= {CNT_W{1'b0}};
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            m_data_q    <= m_data_d;
            m_op_q      <= m_op_d;
            s_data_q    <= s_data_d;
            s_op_q      <= s_op_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= (state_d != FULL);
            out_valid_q <= (state_d != EMPTY);
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = m_data_q;
    assign out_op    = m_op_q;
    assign acc_count = cnt_q;

endmodule

// File: tb/tb_gate_pipe.sv
// Self-checking bench for gate_pipe: truth table, backpressure, async reset, counter wrap,
// randomized stalls against a queue model, and width/operand-count corners.
module tb_gate_pipe;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // Main instance: WIDTH=4, NIN=3, CNT_W=4
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [2:0]  in_op, out_op;
    logic [11:0] in_data;
    logic [3:0]  out_data, acc_count;

    gate_pipe #(.WIDTH(4), .NIN(3), .CNT_W(4)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_op(out_op), .acc_count(acc_count));

    // Corner instances share handshake and op inputs
    logic          c_valid, c_ready;
    logic [2:0]    c_op;
    logic [7:0]    c1_data;
    logic [127:0]  c2_data;
    logic          c1_in_ready, c1_out_valid, c2_in_ready, c2_out_valid;
    logic [0:0]    c1_out_data;
    logic [63:0]   c2_out_data;
    logic [2:0]    c1_out_op, c2_out_op;
    logic [15:0]   c1_acc, c2_acc;

    gate_pipe #(.WIDTH(1), .NIN(8)) dut1 (
        .clk(clk), .rst(rst), .in_valid(c_valid), .in_ready(c1_in_ready), .in_op(c_op),
        .in_data(c1_data), .out_valid(c1_out_valid), .out_ready(c_ready),
        .out_data(c1_out_data), .out_op(c1_out_op), .acc_count(c1_acc));

    gate_pipe #(.WIDTH(64), .NIN(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(c_valid), .in_ready(c2_in_ready), .in_op(c_op),
        .in_data(c2_data), .out_valid(c2_out_valid), .out_ready(c_ready),
        .out_data(c2_out_data), .out_op(c2_out_op), .acc_count(c2_acc));

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [2:0] op;
        logic [3:0] exp;
    } vec_t;

    typedef struct {
        logic [3:0] data;
        logic [2:0] op;
    } item_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: per bit, count the ones across operands and apply the op's rule.
    function automatic logic [63:0] ref_fn(input logic [2:0] op, input logic [511:0] d,
                                           input int w, input int n);
        logic [63:0] r;
        int ones;
        r = 64'd0;
        for (int b = 0; b < w; b++) begin
            ones = 0;
            for (int k = 0; k < n; k++) ones += int'(d[k*w+b]);
            case (op)
                3'd0:    r[b] = (ones == n);
                3'd1:    r[b] = (ones > 0);
                3'd2:    r[b] = (ones % 2 == 1);
                3'd3:    r[b] = (ones != n);
                3'd4:    r[b] = (ones == 0);
                3'd5:    r[b] = (ones % 2 == 0);
                3'd6:    r[b] = !d[b];
                3'd7:    r[b] = d[b];
                default: r[b] = 1'b0;
            endcase
        end
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid = 1'b0; out_ready = 1'b0; in_op = 3'd0; in_data = 12'd0;
        c_valid = 1'b0; c_ready = 1'b0; c_op = 3'd0; c1_data = 8'd0; c2_data = 128'd0;
        @(negedge clk);
        rst = 1'b1;
        #3;
        rst = 1'b0;
        step();
    endtask

    vec_t  vecs[8];
    item_t q[$];

    initial begin
        logic [3:0]  cnt_m;
        logic [3:0]  prev_data;
        logic        prev_stall;
        int          accepted, cyc;
        logic        ifire, ofire;
        item_t       it;
        logic [63:0] e1, e2;

        vecs[0] = '{3'd0, 4'b0000}; vecs[1] = '{3'd1, 4'b1110};
        vecs[2] = '{3'd2, 4'b0000}; vecs[3] = '{3'd3, 4'b1111};
        vecs[4] = '{3'd4, 4'b0001}; vecs[5] = '{3'd5, 4'b1111};
        vecs[6] = '{3'd6, 4'b0011}; vecs[7] = '{3'd7, 4'b1100};

        // Reset state
        do_reset();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data",  64'(out_data),  64'd0);
        chk("rst_out_op",    64'(out_op),    64'd0);
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        chk("rst_acc",       64'(acc_count), 64'd0);

        // Truth sweep, back-to-back with latency 1
        out_ready = 1'b1; in_valid = 1'b1;
        in_data = {4'b0110, 4'b1010, 4'b1100};
        for (int i = 0; i < 8; i++) begin
            in_op = vecs[i].op;
            step();
            chk("truth_valid", 64'(out_valid), 64'd1);
            chk("truth_data",  64'(out_data),  64'(vecs[i].exp));
            chk("truth_op",    64'(out_op),    64'(vecs[i].op));
            chk("truth_ready", 64'(in_ready),  64'd1);
        end
        in_valid = 1'b0;
        step();
        chk("truth_drain", 64'(out_valid), 64'd0);
        chk("truth_acc",   64'(acc_count), 64'd8);

        // Backpressure: 3 sends with out_ready low, BUF op tags operand 0
        do_reset();
        in_op = 3'd7; in_valid = 1'b1; in_data = 12'd1;
        step();
        chk("bp_ready1", 64'(in_ready), 64'd1);
        chk("bp_data1",  64'(out_data), 64'd1);
        in_data = 12'd2;
        step();
        chk("bp_ready2", 64'(in_ready), 64'd0);
        chk("bp_data2",  64'(out_data), 64'd1);
        in_data = 12'd3;
        step();
        chk("bp_held_ready", 64'(in_ready),  64'd0);
        chk("bp_held_data",  64'(out_data),  64'd1);
        chk("bp_held_acc",   64'(acc_count), 64'd2);
        out_ready = 1'b1;
        step();
        chk("bp_pop_data", 64'(out_data),  64'd2);
        chk("bp_pop_rdy",  64'(in_ready),  64'd1);
        chk("bp_pop_acc",  64'(acc_count), 64'd2);
        step();
        chk("bp_third_data", 64'(out_data),  64'd3);
        chk("bp_third_acc",  64'(acc_count), 64'd3);
        in_valid = 1'b0;
        step();
        chk("bp_empty", 64'(out_valid), 64'd0);

        // Async reset with two results buffered
        do_reset();
        in_op = 3'd1; in_valid = 1'b1; in_data = 12'h0F0;
        step();
        step();
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", 64'(out_valid), 64'd0);
        chk("arst_ready", 64'(in_ready),  64'd1);
        chk("arst_acc",   64'(acc_count), 64'd0);
        rst = 1'b0;
        step();
        chk("arst_after", 64'(out_valid), 64'd0);

        // Counter wrap: 17 accepts on a 4-bit counter
        do_reset();
        out_ready = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 17; i++) step();
        chk("wrap_acc", 64'(acc_count), 64'd1);

        // Randomized stalls against the queue model
        do_reset();
        q.delete();
        cnt_m = 4'd0; accepted = 0; cyc = 0; prev_stall = 1'b0; prev_data = 4'd0;
        while (accepted < 200 && cyc < 3000) begin
            chk("rnd_valid", 64'(out_valid), 64'(q.size() != 0));
            chk("rnd_ready", 64'(in_ready),  64'(q.size() < 2));
            chk("rnd_acc",   64'(acc_count), 64'(cnt_m));
            if (q.size() != 0) begin
                chk("rnd_data", 64'(out_data), 64'(q[0].data));
                chk("rnd_op",   64'(out_op),   64'(q[0].op));
            end
            if (prev_stall) chk("rnd_stable", 64'(out_data), 64'(prev_data));
            in_valid  = 1'($urandom);
            out_ready = ($urandom_range(0, 2) != 0);
            in_op     = 3'($urandom);
            in_data   = 12'($urandom);
            ifire = in_valid && (q.size() < 2);
            ofire = out_ready && (q.size() != 0);
            prev_stall = (q.size() != 0) && !out_ready;
            prev_data  = out_data;
            if (ofire) void'(q.pop_front());
            if (ifire) begin
                it.data = ref_fn(in_op, 512'(in_data), 4, 3);
                it.op   = in_op;
                q.push_back(it);
                cnt_m++;
                accepted++;
            end
            step();
            cyc++;
        end
        chk("rnd_budget", 64'(accepted >= 200), 64'd1);

        // Corners: WIDTH=1/NIN=8 and WIDTH=64/NIN=2, streaming with out_ready high
        do_reset();
        c_valid = 1'b1; c_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (i == 0) begin
                c_op = 3'd2; c1_data = 8'b1011_0010; c2_data = {$urandom, $urandom, $urandom, $urandom};
            end else if (i == 1) begin
                c_op = 3'd4; c1_data = 8'd0; c2_data = 128'd0;
            end else begin
                c_op = 3'($urandom); c1_data = 8'($urandom);
                c2_data = {$urandom, $urandom, $urandom, $urandom};
            end
            e1 = ref_fn(c_op, 512'(c1_data), 1, 8);
            e2 = ref_fn(c_op, 512'(c2_data), 64, 2);
            step();
            chk("c1_valid", 64'(c1_out_valid), 64'd1);
            chk("c1_data",  64'(c1_out_data),  e1);
            chk("c2_valid", 64'(c2_out_valid), 64'd1);
            chk("c2_data",  c2_out_data,       e2);
            if (i == 0) begin
                chk("c1_parity", 64'(c1_out_data), 64'd0);
                chk("c2_parity", c2_out_data, c2_data[63:0] ^ c2_data[127:64]);
            end
            if (i == 1) begin
                chk("c1_nor0", 64'(c1_out_data), 64'd1);
                chk("c2_nor0", c2_out_data, 64'hFFFF_FFFF_FFFF_FFFF);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gate_pipe.md
Name: gate_pipe

Overview:
- Parametrised, registered multi-input logic gate with a valid/ready stream interface.
- Per transaction it applies a selectable bitwise function across NIN operands of WIDTH bits.
- Result passes through a 2-entry skid buffer, so in_ready is a registered signal and the block sustains one result per cycle.
- It is the clocked, multi-operand, multi-mode successor to the single combinational two-input gates in the modelling-style exercises, and a reusable leaf for datapath experiments.

Parameters:
- WIDTH, 8, operand and result width in bits (1..64).
- NIN, 2, number of operands per transaction (2..8).
- CNT_W, 16, width of the accepted-transaction counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-high.
- in_valid  input  1  operand set and op are valid.
- in_ready  output  1  block can accept; registered.
- in_op  input  3  function select (see Behaviour).
- in_data  input  NIN*WIDTH  operand k at bits [k*WIDTH +: WIDTH]; operand 0 is the LSB slice.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  downstream accepts.
- out_data  output  WIDTH  result.
- out_op  output  3  op that produced out_data.
- acc_count  output  CNT_W  number of accepted input transactions.

Behaviour:
- Reset (async assert, sync-released use): out_valid=0, out_data=0, out_op=0, in_ready=1, acc_count=0, skid entries empty. Reset mid-transfer discards all held results; no partial output.
- Accept: the input transfers on a rising edge when in_valid && in_ready. Output transfers when out_valid && out_ready.
- Op encoding, bitwise across all NIN operands:
  - 0 AND, 1 OR, 2 XOR (odd parity per bit).
  - 3 NAND, 4 NOR, 5 XNOR (inverted XOR).
  - 6 NOT operand 0. 7 BUF operand 0. Other operands are ignored for ops 6 and 7.
- Latency: result of an accepted transaction appears on out_data/out_valid on the next cycle when the buffer is empty. Throughput is 1 per cycle while out_ready=1.
- Skid buffer: main register M and skid register S.
  - States EMPTY (M,S empty), ONE (M full), FULL (M,S full).
  - EMPTY: accept -> ONE.
  - ONE: accept & !out_fire -> FULL (new result into S). Accept & out_fire -> ONE (new result into M). Out_fire only -> EMPTY.
  - FULL: out_fire -> ONE (S moves to M). Otherwise hold.
  - in_ready = state != FULL, registered. No input is accepted in FULL, so no data is ever lost.
- Stability: while out_valid=1 and out_ready=0, out_data and out_op hold steady. Order is strictly FIFO.
- acc_count increments by 1 per accepted transaction and wraps modulo 2^CNT_W with no saturation.
- The result is computed from in_data/in_op sampled at the accept edge. Input changes while in_ready=0 have no effect.

Decomposition:
- Package gate_pipe_pkg:
  - Op localparams: OP_AND=0, OP_OR=1, OP_XOR=2, OP_NAND=3, OP_NOR=4, OP_XNOR=5, OP_NOT=6, OP_BUF=7.
  - Skid state encoding: EMPTY, ONE, FULL.
- One sub-module, gate_reduce: purely combinational, parametrised WIDTH/NIN, takes in_data and op and produces the WIDTH-bit result.
- gate_pipe holds the skid FSM, registers and counter.

Test Plan:
- Reset: assert rst mid-stream with 2 results buffered -> out_valid=0, in_ready=1 and acc_count=0 immediately, without waiting for a clock edge.
- Truth sweep (WIDTH=4, NIN=3): operands 4'b1100, 4'b1010, 4'b0110 with out_ready=1, ops 0..7 back-to-back.
  - Expected: AND=0000, OR=1110, XOR=0000, NAND=1111, NOR=0001, XNOR=1111, NOT=0011, BUF=1100.
  - Results arrive one per cycle at latency 1 with matching out_op.
- Backpressure: out_ready=0, send 3 transactions -> first 2 accepted, in_ready=0 after the second, third held. Raise out_ready -> outputs in order, third accepted the cycle after in_ready returns, no loss or duplication.
- Stall stability: out_ready toggled randomly for 200 transactions -> out_data never changes while out_valid && !out_ready, and the output sequence matches the reference model.
- Counter wrap (CNT_W=4): 17 accepts -> acc_count reads 1.
- Width/operand corners: WIDTH=1 with NIN=8, and WIDTH=64 with NIN=2 -> XOR equals per-bit parity, NOR with all-zero inputs gives all ones.
